// File: rtl/dual_mem_port_arbiter.sv
// Shares one data-memory port between two MEM-stage instructions. Lone requests pass through
// in the same cycle. Conflicts are served inst1 then inst2, which costs one stall cycle.
module dual_mem_port_arbiter #(
   parameter int AW    = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_re_1,
   input  logic             mem_we_1,
   input  logic [AW-1:0]    addr_1,
   input  logic [31:0]      wdata_1,
   input  logic             mem_re_2,
   input  logic             mem_we_2,
   input  logic [AW-1:0]    addr_2,
   input  logic [31:0]      wdata_2,
   output logic [AW-1:0]    dm_addr,
   output logic [31:0]      dm_wdata,
   output logic             dm_re,
   output logic             dm_we,
   input  logic [31:0]      dm_rdata,
   output logic [31:0]      rdata_1,
   output logic [31:0]      rdata_2,
   output logic             stall_mem,
   output logic [CNT_W-1:0] conflict_cnt
);

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] holdRdata;

   logic req1;
   logic req2;
   logic conflict;
   logic useInst1;
   logic useInst2;

   assign req1     = mem_re_1 | mem_we_1;
   assign req2     = mem_re_2 | mem_we_2;
   assign conflict = req1 & req2;

   // In SECOND the frozen inst1 request is still present but must not be replayed.
   assign useInst2 = (state == SECOND) || (!req1 && req2);
   assign useInst1 = (state == IDLE) && req1;

   always_comb begin
      dm_addr  = '0;
      dm_wdata = '0;
      dm_re    = 1'b0;
      dm_we    = 1'b0;
      if (useInst2) begin
         dm_addr  = addr_2;
         dm_wdata = wdata_2;
         dm_re    = mem_re_2;
         dm_we    = mem_we_2;
      end else if (useInst1) begin
         dm_addr  = addr_1;
         dm_wdata = wdata_1;
         dm_re    = mem_re_1;
         dm_we    = mem_we_1;
      end
      if (!reset) begin
         dm_re = 1'b0;
         dm_we = 1'b0;
      end
   end

   assign stall_mem = reset && (state == IDLE) && conflict;
   assign rdata_1   = (state == SECOND) ? holdRdata : dm_rdata;
   assign rdata_2   = dm_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         holdRdata    <= '0;
         conflict_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (conflict) begin
                  holdRdata <= dm_rdata;
                  state     <= SECOND;
                  if (conflict_cnt != '1) begin
                     conflict_cnt <= conflict_cnt + CNT_W'(1);
                  end
               end
            end
            SECOND:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dual_mem_port_arbiter.sv
module tb_dual_mem_port_arbiter;
   localparam int AW    = 8;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             mem_re_1, mem_we_1, mem_re_2, mem_we_2;
   logic [AW-1:0]    addr_1, addr_2, dm_addr;
   logic [31:0]      wdata_1, wdata_2, dm_wdata, dm_rdata, rdata_1, rdata_2;
   logic             dm_re, dm_we, stall_mem;
   logic [CNT_W-1:0] conflict_cnt;

   always #5 clk = ~clk;

   dual_mem_port_arbiter #(.AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .mem_re_1(mem_re_1), .mem_we_1(mem_we_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .mem_re_2(mem_re_2), .mem_we_2(mem_we_2), .addr_2(addr_2), .wdata_2(wdata_2),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_re(dm_re), .dm_we(dm_we),
      .dm_rdata(dm_rdata), .rdata_1(rdata_1), .rdata_2(rdata_2),
      .stall_mem(stall_mem), .conflict_cnt(conflict_cnt)
   );

   // Environment memory seen by the DUT, and the model's own copy of it.
   logic [31:0] mem [256];
   logic [31:0] sh  [256];
   assign dm_rdata = mem[dm_addr];
   int weCnt = 0;
   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_addr] <= dm_wdata;
         weCnt++;
      end
   end

   typedef struct {
      logic        stall, re, we;
      logic [7:0]  addr;
      logic [31:0] wd;
      bit          c1, c2;
      logic [31:0] r1, r2;
      logic [1:0]  cnt;
   } exp_t;

   exp_t expQ[$];
   int   expCnt = 0;
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Model: a pair of instructions costs one cycle per memory access when both
   // need memory, otherwise one cycle; accesses are applied to sh in program order.
   task automatic drive(input logic re1, we1, input logic [7:0] a1, input logic [31:0] w1,
                        input logic re2, we2, input logic [7:0] a2, input logic [31:0] w2);
      exp_t e;
      logic [31:0] v1;
      mem_re_1 = re1; mem_we_1 = we1; addr_1 = a1; wdata_1 = w1;
      mem_re_2 = re2; mem_we_2 = we2; addr_2 = a2; wdata_2 = w2;
      if ((re1 | we1) && (re2 | we2)) begin
         e = '{stall:1, re:re1, we:we1, addr:a1, wd:w1, c1:0, c2:0, r1:0, r2:0, cnt:2'(expCnt)};
         expQ.push_back(e);
         v1 = sh[a1];
         if (we1) sh[a1] = w1;
         expCnt = (expCnt + 1 > 3) ? 3 : expCnt + 1;
         e = '{stall:0, re:re2, we:we2, addr:a2, wd:w2, c1:1, c2:1, r1:v1, r2:sh[a2], cnt:2'(expCnt)};
         expQ.push_back(e);
         if (we2) sh[a2] = w2;
      end else if (re1 | we1) begin
         e = '{stall:0, re:re1, we:we1, addr:a1, wd:w1, c1:1, c2:1, r1:sh[a1], r2:sh[a1], cnt:2'(expCnt)};
         expQ.push_back(e);
         if (we1) sh[a1] = w1;
      end else if (re2 | we2) begin
         e = '{stall:0, re:re2, we:we2, addr:a2, wd:w2, c1:1, c2:1, r1:sh[a2], r2:sh[a2], cnt:2'(expCnt)};
         expQ.push_back(e);
         if (we2) sh[a2] = w2;
      end else begin
         e = '{stall:0, re:0, we:0, addr:0, wd:0, c1:1, c2:1, r1:sh[0], r2:sh[0], cnt:2'(expCnt)};
         expQ.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         chk("m_stall", 32'(stall_mem), 32'(e.stall));
         chk("m_re", 32'(dm_re), 32'(e.re));
         chk("m_we", 32'(dm_we), 32'(e.we));
         chk("m_addr", 32'(dm_addr), 32'(e.addr));
         chk("m_wdata", dm_wdata, e.wd);
         chk("m_cnt", 32'(conflict_cnt), 32'(e.cnt));
         if (e.c1) chk("m_rdata1", rdata_1, e.r1);
         if (e.c2) chk("m_rdata2", rdata_2, e.r2);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
   endtask

   initial begin
      int w0;
      logic [1:0] satExp [5];
      satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 256; i++) begin
         mem[i] = {8'hA5, 8'(i), 8'h5A, ~8'(i)};
      end
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h04] = 32'hAAAA0000;
      mem[8'h08] = 32'h0000BBBB;
      for (int i = 0; i < 256; i++) sh[i] = mem[i];

      // Reset with a conflicting request present: outputs forced inactive.
      reset = 1'b0;
      mem_re_1 = 1; mem_we_1 = 0; addr_1 = 8'h04; wdata_1 = 0;
      mem_re_2 = 1; mem_we_2 = 0; addr_2 = 8'h08; wdata_2 = 0;
      #2;
      chk("rst_stall", 32'(stall_mem), 0);
      chk("rst_re", 32'(dm_re), 0);
      chk("rst_we", 32'(dm_we), 0);
      chk("rst_cnt", 32'(conflict_cnt), 0);
      mem_re_1 = 0; mem_re_2 = 0;
      #10 reset = 1'b1;
      step();

      // inst1 load only
      drive(1, 0, 8'h10, 0, 0, 0, 8'h00, 0); #1;
      chk("t1_re", 32'(dm_re), 1);
      chk("t1_addr", 32'(dm_addr), 32'h10);
      chk("t1_rdata1", rdata_1, 32'hDEADBEEF);
      chk("t1_stall", 32'(stall_mem), 0);
      chk("t1_cnt", 32'(conflict_cnt), 0);
      step();

      // inst2 store only, then read it back
      drive(0, 0, 8'h00, 0, 0, 1, 8'h20, 32'h12345678); #1;
      chk("t2_we", 32'(dm_we), 1);
      chk("t2_addr", 32'(dm_addr), 32'h20);
      chk("t2_wdata", dm_wdata, 32'h12345678);
      chk("t2_stall", 32'(stall_mem), 0);
      step();
      drive(1, 0, 8'h20, 0, 0, 0, 8'h00, 0); #1;
      chk("t2_readback", rdata_1, 32'h12345678);
      step();
      idle(); step();

      // Both load
      drive(1, 0, 8'h04, 0, 1, 0, 8'h08, 0); #1;
      chk("t3_c1_stall", 32'(stall_mem), 1);
      chk("t3_c1_addr", 32'(dm_addr), 32'h04);
      step(); #1;
      chk("t3_c2_stall", 32'(stall_mem), 0);
      chk("t3_c2_addr", 32'(dm_addr), 32'h08);
      chk("t3_rdata1", rdata_1, 32'hAAAA0000);
      chk("t3_rdata2", rdata_2, 32'h0000BBBB);
      chk("t3_cnt", 32'(conflict_cnt), 1);
      step();

      // inst1 store, inst2 load same address
      w0 = weCnt;
      drive(0, 1, 8'h30, 32'h55, 1, 0, 8'h30, 0); #1;
      chk("t4_c1_we", 32'(dm_we), 1);
      step(); #1;
      chk("t4_c2_we", 32'(dm_we), 0);
      chk("t4_rdata2", rdata_2, 32'h55);
      step();
      chk("t4_we_pulses", 32'(weCnt - w0), 1);
      idle(); step();

      // Conflict, then reset during SECOND drops the inst2 store
      mem_re_1 = 1; mem_we_1 = 0; addr_1 = 8'h40; wdata_1 = 0;
      mem_re_2 = 0; mem_we_2 = 1; addr_2 = 8'h44; wdata_2 = 32'h99;
      step(); #1;
      chk("t5_second_addr", 32'(dm_addr), 32'h44);
      chk("t5_second_we", 32'(dm_we), 1);
      chk("t5_second_cnt", 32'(conflict_cnt), 3);
      reset = 1'b0; #1;
      chk("t5_rst_stall", 32'(stall_mem), 0);
      chk("t5_rst_we", 32'(dm_we), 0);
      chk("t5_rst_re", 32'(dm_re), 0);
      chk("t5_rst_cnt", 32'(conflict_cnt), 0);
      @(posedge clk); #2;
      mem_re_1 = 0; mem_we_2 = 0;
      reset = 1'b1;
      expCnt = 0;
      step();
      chk("t5_mem_kept", mem[8'h44], 32'hA5445ABB);
      drive(1, 0, 8'h44, 0, 0, 0, 8'h00, 0); #1;
      chk("t5_idle_stall", 32'(stall_mem), 0);
      chk("t5_idle_rdata1", rdata_1, 32'hA5445ABB);
      step();

      // Back-to-back conflicts with counter saturation
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 8'(k), 0, 1, 0, 8'(k + 8), 0); #1;
         chk("t6_c1_stall", 32'(stall_mem), 1);
         step(); #1;
         chk("t6_c2_stall", 32'(stall_mem), 0);
         chk("t6_cnt", 32'(conflict_cnt), 32'(satExp[k]));
         step();
      end
      idle(); step();
      idle(); step();

      chk("queue_drained", 32'(expQ.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dual_mem_port_arbiter.md
Name: dual_mem_port_arbiter

Overview:
- Shares the single data-memory port between the two MEM-stage instructions of the dual-issue pipeline: inst1, and inst2 from the inst2 EX/MEM register.
- When only one instruction needs memory, its request passes straight through with no penalty.
- When both need memory, it serializes them in program order: inst1 first, then inst2. It stalls the pipeline for one cycle and holds inst1's load data until both results are ready for MEM/WB.
- It also keeps a saturating conflict counter for performance monitoring.

Parameters:
- AW, 8: data-memory address width.
- CNT_W, 16: conflict counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- mem_re_1  in  1  inst1 MEM-stage load enable.
- mem_we_1  in  1  inst1 MEM-stage store enable.
- addr_1  in  AW  inst1 address.
- wdata_1  in  32  inst1 store data.
- mem_re_2  in  1  inst2 load enable (MemReadEn_inst2_Mem).
- mem_we_2  in  1  inst2 store enable (MemWriteEn_inst2_Mem).
- addr_2  in  AW  inst2 address.
- wdata_2  in  32  inst2 store data.
- dm_addr  out  AW  data-memory address.
- dm_wdata  out  32  data-memory write data.
- dm_re  out  1  data-memory read enable.
- dm_we  out  1  data-memory write enable.
- dm_rdata  in  32  data-memory read data; combinational read, valid in the same cycle.
- rdata_1  out  32  load result for inst1, to MEM/WB.
- rdata_2  out  32  load result for inst2, to MEM/WB.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers; hold MEM/WB write.
- conflict_cnt  out  CNT_W  number of serialized conflicts.

Behaviour:
- Definitions:
  - req1 = mem_re_1 | mem_we_1.
  - req2 = mem_re_2 | mem_we_2.
  - conflict = req1 & req2.
- Registers: state, hold_rdata (32), conflict_cnt. All are cleared asynchronously when reset is low:
  - state = IDLE.
  - hold_rdata = 0.
  - conflict_cnt = 0.
- While reset is low, stall_mem, dm_re and dm_we are forced to 0.
- State IDLE:
  - conflict = 0:
    - Port driven by whichever instruction requests (addr, wdata, re, we copied).
    - With no request, dm_re = dm_we = 0, dm_addr = 0 and dm_wdata = 0.
    - rdata_1 = rdata_2 = dm_rdata.
    - stall_mem = 0; stay in IDLE.
  - conflict = 1:
    - Port driven by inst1.
    - stall_mem = 1.
    - At the clock edge: hold_rdata <= dm_rdata, go to SECOND, and conflict_cnt increments, saturating at all-ones.
- State SECOND:
  - The pipeline is frozen, so the inputs are unchanged.
  - Port driven by inst2 only. inst1's request is ignored, so its store is never repeated.
  - stall_mem = 0.
  - rdata_1 = hold_rdata and rdata_2 = dm_rdata.
  - Unconditionally return to IDLE at the next edge.
- Conflict latency: exactly 1 extra cycle. Non-conflict latency: 0.
- Ordering: inst1's access always completes before inst2's, which preserves store→load and store→store order to the same address.
- Back-to-back conflicts: a new conflict arriving in the cycle after SECOND is handled as a fresh conflict. Each conflict costs one stall cycle and one count.
- Counter saturation: conflict_cnt holds at 2^CNT_W−1 and does not wrap.
- Reset mid-operation: reset asserted in SECOND returns state to IDLE immediately. The pending inst2 access is dropped, because the pipeline is also reset.
- rdata outputs for non-load instructions are don't-care, but must be deterministic (the values given above).
- Single clock domain, no internal combinational loops. stall_mem depends only on state and the request inputs.

Test Plan:
- Only inst1 loads, addr_1=0x10, memory holds 0xDEADBEEF → dm_re=1, dm_addr=0x10, rdata_1=0xDEADBEEF in the same cycle; stall_mem=0; conflict_cnt stays 0.
- Only inst2 stores 0x12345678 to 0x20 → dm_we=1, dm_addr=0x20, dm_wdata=0x12345678; no stall; memory[0x20] updated after one edge.
- Both load, addr_1=0x04 (0xAAAA0000), addr_2=0x08 (0x0000BBBB):
  - cycle 1: stall_mem=1, dm_addr=0x04.
  - cycle 2: stall_mem=0, dm_addr=0x08, rdata_1=0xAAAA0000, rdata_2=0x0000BBBB.
  - conflict_cnt=1.
- inst1 stores 0x55 to 0x30 and inst2 loads 0x30 → store served first with a single dm_we pulse, then rdata_2=0x55; no second write in SECOND.
- Conflict, then reset pulsed low during SECOND → state returns to IDLE; stall_mem, dm_we and dm_re are 0 during reset; conflict_cnt=0 and hold_rdata=0 after release.
- CNT_W=2 with 5 consecutive conflicts → conflict_cnt reads 1, 2, 3, 3, 3; each conflict stalls exactly one cycle.
